// File: rtl/bus_cycle_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : bus_cycle_sequencer_if
// Purpose  : Bundles the core memory port, the board-level AD bus, latch and
//            strobe pins, and the DMA HOLD handshake of the pine16 bus
//            cycle sequencer.
// Modports : master - the core/board side (drives req, we, addr, wdata,
//                     ready, ad_in, hold_req; observes everything else)
//            slave  - the sequencer itself
// Revision : 1.0  initial release
// ============================================================================
interface bus_cycle_sequencer_if;
    logic        req;        // core requests a bus cycle
    logic        we;         // 1 = write, 0 = read
    logic [15:0] addr;       // cycle address
    logic [15:0] wdata;      // write data
    logic        ready;      // external device ready
    logic [15:0] ad_in;      // AD bus read-back
    logic [15:0] ad_out;     // AD bus drive value
    logic        ad_oe;      // 1 = drive AD bus
    logic        le;         // latch enable to both 573s
    logic        latch_oe_n; // 573 output enable, active low
    logic        rd_n;       // read strobe, active low
    logic        wr_n;       // write strobe, active low
    logic        ack;        // one-cycle cycle-complete pulse
    logic [15:0] rdata;      // captured read data
    logic        busy;       // sequencer not in IDLE
    logic        hold_req;   // DMA master requests the bus
    logic        hold_ack;   // bus released to DMA master

    modport master (
        output req, we, addr, wdata, ready, ad_in, hold_req,
        input  ad_out, ad_oe, le, latch_oe_n, rd_n, wr_n, ack, rdata, busy, hold_ack
    );

    modport slave (
        input  req, we, addr, wdata, ready, ad_in, hold_req,
        output ad_out, ad_oe, le, latch_oe_n, rd_n, wr_n, ack, rdata, busy, hold_ack
    );
endinterface
`default_nettype wire

// File: rtl/bus_cycle_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : bus_cycle_sequencer
// Purpose  : Runs one multiplexed 16-bit address/data bus cycle at a time:
//            address phase with the 573 latches transparent, optional latch
//            hold, strobed data phase with wait states, then a one-cycle end
//            phase with ack. Hands the whole bus to a DMA master via HOLD.
// Ports    : clk  - single clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - bus_cycle_sequencer_if.slave (core port, AD bus, latch
//                   LE/OE, RD_n/WR_n, HOLD handshake)
// Params   : LE_CYC   cycles LE is high with the address on AD (>=1)
//            HOLD_CYC cycles the address is held after LE falls (0 = none)
//            WAIT_CYC minimum strobe cycles before ready is sampled
// Revision : 1.0  initial release
// ============================================================================
module bus_cycle_sequencer #(
    parameter int LE_CYC   = 1,
    parameter int HOLD_CYC = 1,
    parameter int WAIT_CYC = 1
) (
    input  wire logic            clk,
    input  wire logic            rst,
    bus_cycle_sequencer_if.slave bus
);

    // Phase counters count down to zero; each phase lasts load+1 cycles.
    localparam logic [15:0] c_le_load   = (LE_CYC   < 1) ? 16'd0 : 16'(LE_CYC - 1);
    localparam logic [15:0] c_hold_load = (HOLD_CYC < 1) ? 16'd0 : 16'(HOLD_CYC - 1);
    localparam logic [15:0] c_wait_load = (WAIT_CYC < 1) ? 16'd0 : 16'(WAIT_CYC - 1);
    localparam logic        c_has_hold  = (HOLD_CYC > 0);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_addr  = 3'd1;
    localparam logic [2:0] c_st_hold  = 3'd2;
    localparam logic [2:0] c_st_data  = 3'd3;
    localparam logic [2:0] c_st_end   = 3'd4;
    localparam logic [2:0] c_st_grant = 3'd5;

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_we;

    logic [15:0] r_ad_out;
    logic        r_ad_oe;
    logic        r_le;
    logic        r_latch_oe_n;
    logic        r_rd_n;
    logic        r_wr_n;
    logic        r_ack;
    logic [15:0] r_rdata;
    logic        r_busy;
    logic        r_hold_ack;

    // Outputs are computed for the state being entered, so every pin
    // changes on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_cnt        <= 16'd0;
            r_addr       <= 16'd0;
            r_wdata      <= 16'd0;
            r_we         <= 1'b0;
            r_ad_out     <= 16'd0;
            r_ad_oe      <= 1'b0;
            r_le         <= 1'b0;
            r_latch_oe_n <= 1'b1;
            r_rd_n       <= 1'b1;
            r_wr_n       <= 1'b1;
            r_ack        <= 1'b0;
            r_rdata      <= 16'd0;
            r_busy       <= 1'b0;
            r_hold_ack   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (bus.req) begin
                        // req wins over hold_req in the same cycle
                        r_addr       <= bus.addr;
                        r_we         <= bus.we;
                        r_wdata      <= bus.wdata;
                        r_cnt        <= c_le_load;
                        r_ad_out     <= bus.addr;
                        r_ad_oe      <= 1'b1;
                        r_le         <= 1'b1;
                        r_latch_oe_n <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= c_st_addr;
                    end else if (bus.hold_req) begin
                        r_hold_ack   <= 1'b1;
                        r_latch_oe_n <= 1'b1;
                        r_ad_oe      <= 1'b0;
                        r_le         <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= c_st_grant;
                    end else begin
                        r_latch_oe_n <= 1'b0;
                        r_ad_oe      <= 1'b0;
                        r_le         <= 1'b0;
                        r_busy       <= 1'b0;
                        r_hold_ack   <= 1'b0;
                    end
                end

                c_st_addr, c_st_hold: begin
                    if (r_cnt != 16'd0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else if (r_state == c_st_addr && c_has_hold) begin
                        // LE falls, address stays on AD for the latch hold time
                        r_le    <= 1'b0;
                        r_cnt   <= c_hold_load;
                        r_state <= c_st_hold;
                    end else begin
                        r_le     <= 1'b0;
                        r_ad_oe  <= r_we;
                        r_ad_out <= r_we ? r_wdata : r_addr;
                        r_rd_n   <= r_we;
                        r_wr_n   <= ~r_we;
                        r_cnt    <= c_wait_load;
                        r_state  <= c_st_data;
                    end
                end

                c_st_data: begin
                    // ready is only looked at once the minimum strobe width is met
                    if (r_cnt != 16'd0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else if (bus.ready) begin
                        if (!r_we) begin
                            r_rdata <= bus.ad_in;
                        end
                        r_rd_n  <= 1'b1;
                        r_wr_n  <= 1'b1;
                        r_ack   <= 1'b1;
                        r_state <= c_st_end;
                    end
                end

                c_st_end: begin
                    r_ad_oe      <= 1'b0;
                    r_latch_oe_n <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= c_st_idle;
                end

                c_st_grant: begin
                    if (!bus.hold_req) begin
                        r_hold_ack   <= 1'b0;
                        r_latch_oe_n <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= c_st_idle;
                    end
                end

                default: begin
                    r_ad_oe      <= 1'b0;
                    r_le         <= 1'b0;
                    r_latch_oe_n <= 1'b0;
                    r_rd_n       <= 1'b1;
                    r_wr_n       <= 1'b1;
                    r_busy       <= 1'b0;
                    r_hold_ack   <= 1'b0;
                    r_state      <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.ad_out     = r_ad_out;
    assign bus.ad_oe      = r_ad_oe;
    assign bus.le         = r_le;
    assign bus.latch_oe_n = r_latch_oe_n;
    assign bus.rd_n       = r_rd_n;
    assign bus.wr_n       = r_wr_n;
    assign bus.ack        = r_ack;
    assign bus.rdata      = r_rdata;
    assign bus.busy       = r_busy;
    assign bus.hold_ack   = r_hold_ack;

endmodule
`default_nettype wire
